// File: rtl/bist_controller.sv
// bist_controller: LFSR pattern generator and MISR sequencer for logic BIST.
// It runs reset, compaction and compare phases, then reports pass/fail.
module bist_controller #(
  parameter int TPG_W = 18,
  parameter int SIG_W = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [TPG_W-1:0] tpg_poly,
  input  logic [TPG_W-1:0] tpg_seed,
  input  logic [SIG_W-1:0] golden,
  input  logic [SIG_W-1:0] misr_sig,
  output logic [TPG_W-1:0] tpg_out,
  output logic             misr_rst,
  output logic             misr_en,
  output logic             busy,
  output logic             done,
  output logic             pass
);
  typedef enum logic [2:0] {IDLE, INIT, RUN, CMP, DONE} state_t;
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, num_q, num_d;
  logic [SIG_W-1:0] gold_q, gold_d;
  logic [TPG_W-1:0] tpg_d, tpg_step;
  logic misr_rst_d, misr_en_d, busy_d, done_d, pass_d, act;
  assign tpg_step = ({TPG_W{tpg_out[0]}} & tpg_poly) ^ (tpg_out >> 1);
  assign act = (state == INIT) || (state == RUN) || (state == CMP);
  // Every output is computed one cycle ahead so the MISR controls come straight from flops.
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    num_d = num_q;
    gold_d = gold_q;
    tpg_d = tpg_out;
    misr_rst_d = 1'b0;
    misr_en_d = 1'b0;
    busy_d = busy;
    done_d = done;
    pass_d = pass;
    if (act && abort) begin
      state_d = IDLE;
      tpg_d = '0;
      busy_d = 1'b0;
      done_d = 1'b0;
      pass_d = 1'b0;
    end else if (!act && start) begin
      state_d = INIT;
      num_d = num_patterns;
      gold_d = golden;
      tpg_d = tpg_seed;
      misr_rst_d = 1'b1;
      busy_d = 1'b1;
      done_d = 1'b0;
      pass_d = 1'b0;
    end else begin
      case (state)
        INIT: begin
          state_d = (num_q != '0) ? RUN : CMP;
          misr_en_d = (num_q != '0);
          cnt_d = num_q;
        end
        RUN: begin
          tpg_d = tpg_step;
          cnt_d = cnt - 1'b1;
          state_d = (cnt == 1) ? CMP : RUN;
          misr_en_d = (cnt != 1);
        end
        CMP: begin
          state_d = DONE;
          pass_d = (misr_sig == gold_q);
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      num_q <= '0;
      gold_q <= '0;
      tpg_out <= '0;
      misr_rst <= 1'b0;
      misr_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      num_q <= num_d;
      gold_q <= gold_d;
      tpg_out <= tpg_d;
      misr_rst <= misr_rst_d;
      misr_en <= misr_en_d;
      busy <= busy_d;
      done <= done_d;
      pass <= pass_d;
    end
  end
endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller: scoreboard bench for bist_controller with a behavioural CUT and MISR.
// Stimulus queues expected patterns/results; a negedge monitor pops and compares them.
module tb_bist_controller;
  localparam logic [9:0] MSEED = 10'h2A5;
  localparam logic [9:0] MPOLY = 10'h204;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] num_patterns = '0;
  logic [17:0] tpg_poly = '0, tpg_seed = '0, tpg_out;
  logic [9:0] golden = '0, misr = '0;
  logic misr_rst, misr_en, busy, done, pass;
  int n_chk = 0, n_fail = 0, en_cnt = 0, rst_cnt = 0;
  logic done_prev = 1'b0, busy_prev = 1'b0;
  logic [17:0] tpg_q[$];
  int len_q[$];
  bit pass_q[$];

  bist_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_patterns(num_patterns), .tpg_poly(tpg_poly), .tpg_seed(tpg_seed),
    .golden(golden), .misr_sig(misr), .tpg_out(tpg_out), .misr_rst(misr_rst),
    .misr_en(misr_en), .busy(busy), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] tstep(input logic [17:0] q, input logic [17:0] p);
    return ({18{q[0]}} & p) ^ (q >> 1);
  endfunction
  function automatic logic [9:0] cut(input logic [17:0] p);
    return p[9:0] ^ {2'b00, p[17:10]};
  endfunction
  function automatic logic [9:0] mstep(input logic [9:0] m, input logic [9:0] d);
    return ({10{m[0]}} & MPOLY) ^ (m >> 1) ^ d;
  endfunction
  function automatic logic [9:0] model(input logic [17:0] seed, input logic [17:0] poly, input int n);
    logic [9:0] m = MSEED;
    logic [17:0] p = seed;
    for (int k = 0; k < n; k++) begin
      m = mstep(m, cut(p));
      p = tstep(p, poly);
    end
    return m;
  endfunction

  // Environment: CUT plus MISR driven by the DUT's controls.
  always @(posedge clk)
    if (misr_rst) misr <= MSEED;
    else if (misr_en) misr <= mstep(misr, cut(tpg_out));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (misr_en) begin
      if (tpg_q.size() == 0) chk("tpg_q_nonempty", 32'(tpg_q.size() != 0), 1);
      else chk("tpg_out", tpg_out, tpg_q.pop_front());
      en_cnt++;
    end
    if (misr_rst) rst_cnt++;
    if (done && !done_prev) begin
      if (len_q.size() == 0) chk("len_q_nonempty", 32'(len_q.size() != 0), 1);
      else begin
        chk("en_cycles", en_cnt, len_q.pop_front());
        chk("rst_cycles", rst_cnt, 1);
        chk("pass", pass, pass_q.pop_front());
      end
      en_cnt = 0;
      rst_cnt = 0;
    end
    if (!busy && busy_prev && !done) begin
      en_cnt = 0;
      rst_cnt = 0;
    end
    done_prev = done;
    busy_prev = busy;
  end

  // sa/aa/ra: loop index (0 = INIT, k = RUN cycle k-1) at which to pulse start, abort or reset; -1 = never.
  task automatic do_run(input logic [17:0] seed, input logic [17:0] poly, input int n,
                        input logic [9:0] gold, input bit ep, input int sa, input int aa, input int ra);
    logic [17:0] p = seed;
    int np = n;
    int k;
    if (aa >= 0 && aa < np) np = aa;
    if (ra >= 0 && ra - 1 < np) np = ra - 1;
    for (int i = 0; i < np; i++) begin
      tpg_q.push_back(p);
      p = tstep(p, poly);
    end
    if (aa < 0 && ra < 0) begin
      len_q.push_back(n);
      pass_q.push_back(ep);
    end
    tpg_seed = seed;
    tpg_poly = poly;
    num_patterns = 16'(n);
    golden = gold;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("start_clears", {done, pass, misr_rst, busy}, 4'b0011);
    chk("init_tpg", tpg_out, seed);
    for (k = 0; k < n + 10 && !done; k++) begin
      if (k == ra) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst", {misr_en, busy, done, pass, misr_rst, 18'(tpg_out)}, 0);
        cyc(2);
        rst_n = 1'b1;
        tpg_q.delete();
        cyc(1);
        chk("post_rst", {misr_en, busy, done, pass, misr_rst, 18'(tpg_out)}, 0);
        return;
      end
      start = (k == sa);
      abort = (k == aa);
      if (k == sa) begin
        num_patterns = 16'(n + 3);
        golden = ~gold;
      end
      cyc(1);
      start = 1'b0;
      num_patterns = 16'(n);
      golden = gold;
      if (k == aa) begin
        abort = 1'b0;
        chk("abort", {misr_en, misr_rst, busy, done, pass}, 0);
        cyc(2);
        chk("abort_idle", {misr_en, misr_rst, busy, done, pass}, 0);
        return;
      end
    end
    chk("run_len", k, n + 2);
    chk("done", done, 1);
  endtask

  initial begin
    logic [9:0] g;
    #1;
    chk("reset_outs", {misr_en, busy, done, pass, misr_rst, 18'(tpg_out)}, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("idle_outs", {misr_en, busy, done, pass, misr_rst, 18'(tpg_out)}, 0);
    do_run(18'h00001, 18'h20400, 5, 10'h000, 1'b0, -1, -1, 3);
    g = model(18'h00001, 18'h20400, 3);
    do_run(18'h00001, 18'h20400, 3, g, 1'b1, -1, -1, -1);
    do_run(18'h00001, 18'h20400, 3, g ^ 10'h001, 1'b0, -1, -1, -1);
    do_run(18'h3ABCD, 18'h20400, 0, 10'h2A5, 1'b1, -1, -1, -1);
    g = model(18'h0F00D, 18'h20400, 4);
    do_run(18'h0F00D, 18'h20400, 4, g, 1'b1, 2, -1, -1);
    do_run(18'h0F00D, 18'h20400, 4, g, 1'b1, -1, 2, -1);
    g = model(18'h2F0F1, 18'h24000, 6);
    do_run(18'h2F0F1, 18'h24000, 6, g, 1'b1, -1, -1, -1);
    g = model(18'h15555, 18'h20400, 5);
    do_run(18'h15555, 18'h20400, 5, g, 1'b1, -1, -1, -1);
    cyc(3);
    chk("tpg_q_drained", tpg_q.size(), 0);
    chk("len_q_drained", len_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Built-in self-test sequencer that sits directly upstream of the MISR signature register.
- Generates pseudo-random test patterns with an internal LFSR for the circuit under test (CUT).
- Sequences the MISR through reset, compaction and final-signature compare, then reports pass/fail.
- The CUT is combinational between tpg_out and the MISR d_in. The MISR rst is active-high and its seed/poly are tied externally.

Parameters:
TPG_W, 18, pattern width; matches MISR d_in width
SIG_W, 10, signature width; matches MISR d_out width
CNT_W, 16, pattern-count width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a test run; sampled in IDLE/DONE only
abort  input  1  cancel an in-progress run
num_patterns  input  CNT_W  number of patterns to apply; latched at start
tpg_poly  input  TPG_W  LFSR feedback taps
tpg_seed  input  TPG_W  LFSR initial pattern
golden  input  SIG_W  expected signature; latched at start
misr_sig  input  SIG_W  MISR d_out
tpg_out  output  TPG_W  current test pattern to the CUT
misr_rst  output  1  active-high reset to the MISR
misr_en  output  1  MISR compaction enable
busy  output  1  high in INIT, RUN, COMPARE
done  output  1  run complete
pass  output  1  signature matched; valid when done=1

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, all outputs 0 including tpg_out, count=0, latched golden=0. Takes effect immediately mid-run; misr_en drops without waiting for a clock.
- All outputs are driven from flops: no combinational decode on misr_rst or misr_en.
- TPG step (right-shift Galois, same form as the MISR):
  - next[TPG_W-1] = q[0]&poly[TPG_W-1]
  - next[i] = (q[0]&poly[i]) ^ q[i+1] for i < TPG_W-1
  - tpg_poly is sampled every step; it must be held stable during a run.
- IDLE: outputs low.
  - start=1 -> at the edge: latch num_patterns and golden, tpg_out<=tpg_seed, done<=0, pass<=0, go INIT.
- INIT (exactly 1 cycle): misr_rst=1, busy=1, tpg_out holds the seed.
  - Next state: RUN if num_patterns!=0, else COMPARE.
- RUN (exactly num_patterns cycles): misr_en=1, busy=1.
  - RUN cycle k (0-based) presents pattern P_k, with P_0=seed.
  - The MISR captures CUT(P_k) on the edge ending cycle k; the TPG steps on the same edge.
  - Counter loads N on entry and decrements each RUN cycle.
  - At count==1: go COMPARE, misr_en<=0.
- COMPARE (1 cycle): busy=1, misr_en=0. misr_sig is final.
  - At the edge: pass<=(misr_sig==golden_q), done<=1, go DONE.
- DONE: done=1, pass held, busy=0, tpg_out holds.
  - start=1 -> same actions as from IDLE (done/pass cleared, go INIT).
- abort=1 in INIT/RUN/COMPARE: next edge -> IDLE; misr_en=0, misr_rst=0, busy=0, done=0, pass=0.
  - abort has priority over all transitions and is ignored in IDLE and DONE.
- start while busy: ignored.
- start and abort together in IDLE/DONE: start wins.
- Count width: num_patterns up to 2^CNT_W-1; no wrap. num_patterns=0 skips RUN.

Test Plan:
1. Reset: assert rst_n=0 during RUN cycle 2 -> misr_en, busy, done, pass, tpg_out go 0 before the next edge; after release, state IDLE, all outputs 0.
2. Sequence: seed=18'h00001, poly=18'h20400, N=3, start pulse ->
   - one cycle misr_rst=1;
   - then exactly 3 cycles misr_en=1 with tpg_out=18'h00001, 18'h20400, 18'h10200;
   - then one COMPARE cycle; done=1 on the following edge.
3. Pass/fail: as test 2 with golden = reference-model MISR signature (MISR seed/poly fixed in bench) -> pass=1; rerun with golden^10'h001 -> done=1, pass=0.
4. Zero patterns: N=0, MISR seed 10'h2A5, golden=10'h2A5 -> misr_en never asserted; INIT, COMPARE, then DONE with pass=1 after 2 cycles.
5. Abort/start collision: pulse start during RUN -> ignored, run length unchanged. Then abort=1 in RUN cycle 1 -> IDLE next edge, misr_en=0, done=0, pass=0.
6. Restart from DONE: after a pass, start with N=5 -> done and pass clear on that edge; 5 misr_en cycles; new result reported.
